// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and line levels.
// Optional build macro FIFO_UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREFETCH = 3'd1,
    ST_START    = 3'd2,
    ST_DATA     = 3'd3,
`ifdef FIFO_UART_TX_PARITY_EN
    ST_PARITY   = 3'd4,
`endif
    ST_STOP     = 3'd5
  } state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: o_tick pulses on the last cycle of each CLKS_PER_BIT period.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Tick on the final count of the period while enabled.
  always_comb begin
    o_tick = i_enable && (cnt_q == CNT_LAST);
  end

  // Next count: clear wins, otherwise wrap at the end of each period.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge i_clk) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one word per frame and serializes it
// LSB first on o_tx. Build macro FIFO_UART_TX_PARITY_EN appends an even
// parity bit after the data bits.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned WORD_LENGTH  = 8,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [WORD_LENGTH-1:0] i_fifo_data,
  input  logic                   i_fifo_empty,
  output logic                   o_fifo_read_en,
  output logic                   o_tx,
  output logic                   o_busy
);

  localparam int unsigned BIT_W = $clog2(WORD_LENGTH + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_LENGTH - 1);

  state_e                 state_q, state_d;
  logic [WORD_LENGTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   read_en_q, read_en_d;
  logic                   tick, baud_en, baud_clr;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (baud_clr),
    .i_enable(baud_en),
    .o_tick  (tick)
  );

  // Baud timer runs in the timed states and restarts on every state entry.
  always_comb begin
    baud_en  = (state_q != ST_IDLE) && (state_q != ST_PREFETCH);
    baud_clr = (state_d != state_q);
  end

  // State, datapath and registered-output flops.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= UART_IDLE_LEVEL;
      busy_q    <= 1'b0;
      read_en_q <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      read_en_q <= read_en_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next-state logic; timed states advance only on the baud tick.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (!i_fifo_empty) state_d = ST_PREFETCH;
      ST_PREFETCH: state_d = ST_START;
      ST_START:    if (tick) state_d = ST_DATA;
`ifdef FIFO_UART_TX_PARITY_EN
      ST_DATA:     if (tick && bit_cnt_q == BIT_LAST) state_d = ST_PARITY;
      ST_PARITY:   if (tick) state_d = ST_STOP;
`else
      ST_DATA:     if (tick && bit_cnt_q == BIT_LAST) state_d = ST_STOP;
`endif
      ST_STOP:     if (tick) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Datapath: capture the head word in PREFETCH, shift after each data bit.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    if (state_q == ST_PREFETCH) begin
      shift_d   = i_fifo_data;
      bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_d  = ^i_fifo_data;
`endif
    end else if (state_q == ST_DATA && tick) begin
      shift_d   = shift_q >> 1;
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
    end
  end

  // Outputs are decoded from the upcoming state so the flops line up with it.
  always_comb begin
    tx_d      = UART_IDLE_LEVEL;
    busy_d    = (state_d != ST_IDLE);
    read_en_d = (state_d == ST_PREFETCH);
    unique case (state_d)
      ST_START:  tx_d = UART_START_LEVEL;
      ST_DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      ST_STOP:   tx_d = UART_STOP_LEVEL;
      default:   tx_d = UART_IDLE_LEVEL;
    endcase
  end

  assign o_tx           = tx_q;
  assign o_busy         = busy_q;
  assign o_fifo_read_en = read_en_q;

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream consumer for the internal FIFO: drains words from the FIFO read port and serializes each as an asynchronous UART frame on a single TX line. Sits between the `FIFO_internal` read side (`o_data_out`, `o_empty`, `i_read_en`) and the chip-level TX pin. It owns the FIFO pop strobe, so the FIFO never needs a separate read controller.

## Interface

- `WORD_LENGTH`, 8: data bits per frame; must equal the FIFO word width.
- `CLKS_PER_BIT`, 868: `i_clk` cycles per UART bit, ≥ 2 (868 gives 115200 baud at 100 MHz).

Ports:

- `i_clk` in 1: clock.
- `i_reset` in 1: reset. Synchronous, active-high.
- `i_fifo_data` in `WORD_LENGTH`: FIFO head word (FIFO `o_data_out`).
- `i_fifo_empty` in 1: FIFO empty flag.
- `o_fifo_read_en` out 1: single-cycle pop strobe to FIFO `i_read_en`.
- `o_tx` out 1: serial line, idle high.
- `o_busy` out 1: high from PREFETCH through the end of STOP.

## Operation

- FSM states: IDLE, PREFETCH, START, DATA, PARITY (macro only), STOP.
- IDLE: `o_tx`=1. If `i_fifo_empty`=0, go to PREFETCH.
- PREFETCH: one cycle. The FIFO head has been stable for at least one cycle, which covers a registered RAM read. In this cycle:
  - latch `i_fifo_data` into the shift register;
  - assert `o_fifo_read_en`=1;
  - go to START.
- START: `o_tx`=0 for `CLKS_PER_BIT` cycles.
- DATA: `WORD_LENGTH` bits, LSB first, each held `CLKS_PER_BIT` cycles.
  - Bit counter width: `$clog2(WORD_LENGTH+1)`.
  - Shift right after each bit.
- PARITY: one bit period (see Configuration).
- STOP: `o_tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- Baud counter:
  - width `$clog2(CLKS_PER_BIT)`;
  - cleared on every state entry;
  - the bit period ends when the count reaches `CLKS_PER_BIT-1`.
- `o_fifo_read_en` is asserted only in PREFETCH and only while `i_fifo_empty`=0, so the block never pops an empty FIFO.
- `i_fifo_data` is ignored outside PREFETCH. FIFO writes during a frame do not affect the frame in flight.

## Timing

- All outputs are registered.
- Reset values: `o_tx`=1, `o_busy`=0, `o_fifo_read_en`=0, state IDLE, counters 0, shift register 0.
- Latency: `i_fifo_empty` falls at cycle N (seen in IDLE).
  - PREFETCH at N+1, pop strobe high during N+1.
  - `o_tx` falls at N+2.
- Frame length: (`WORD_LENGTH`+2) × `CLKS_PER_BIT` cycles, plus `CLKS_PER_BIT` with parity.
- Back-to-back words: STOP ends, then one IDLE cycle, one PREFETCH cycle, then the next start bit. Inter-frame gap is 2 cycles of extra idle-high.
- Reset mid-frame: the next cycle has `o_tx`=1 and state IDLE. The popped word is discarded and not re-read.
- Reset asserted together with a PREFETCH cycle: reset wins. The registered pop strobe stays 0.
- FIFO becomes empty during a frame: no effect until IDLE.

## Configuration

- `FIFO_UART_TX_PARITY_EN` defined:
  - PARITY state is compiled in after DATA.
  - It sends even parity, the XOR of the latched word.
  - Frame is (`WORD_LENGTH`+3) × `CLKS_PER_BIT` cycles.
- Not defined: PARITY state and the parity register are absent, and DATA goes directly to STOP.

## Structure

- Shared package `uart_pkg` holds:
  - the FSM state enum/localparams;
  - `UART_IDLE_LEVEL`=1, `UART_START_LEVEL`=0, `UART_STOP_LEVEL`=1.
- One sub-module, `uart_baud_tick`:
  - parameterised by `CLKS_PER_BIT`;
  - inputs clear/enable;
  - output `o_tick` pulses on the last cycle of each bit period.
  - The FSM advances only on `o_tick`.

## Test plan

Bench uses `CLKS_PER_BIT`=4 and `WORD_LENGTH`=8.

- Reset, FIFO empty for 50 cycles -> `o_tx`=1, `o_busy`=0, zero pops.
- FIFO holds 0xA5, empty falls at cycle N -> one pop at N+1; `o_tx` goes low at N+2; bits 1,0,1,0,0,1,0,1 follow at 4-cycle spacing; stop high; frame is 40 cycles (44 with parity, parity bit 0).
- FIFO holds 0x01, 0xFF, 0x80 -> exactly 3 pops, frames decode in order, 2-cycle gap between stop end and next start.
- `i_reset` pulsed at cycle 17 of a frame -> `o_tx`=1 on the next cycle; the next frame starts only after the FIFO is non-empty and the PREFETCH sequence repeats.
- FIFO drained to empty mid-frame, then 0x3C written after STOP -> no pop while empty; 0x3C is sent after IDLE→PREFETCH.
- With `FIFO_UART_TX_PARITY_EN`, word 0x07 -> parity bit 1.
